// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the MIPS pipeline stall/flush scheduler (package mips_pipe_pkg).
// Holds the FSM state type, the r0 index constant and the stall-class enum used by the stall counters.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        BR_LOAD  = 2'd1,
        MD_WAIT  = 2'd2,
        MEM_WAIT = 2'd3
    } state_t;

    // Register r0 is hard-wired to zero, so it can never be a hazard.
    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        SC_NONE   = 2'd0,
        SC_LOAD   = 2'd1,
        SC_BRANCH = 2'd2,
        SC_MULDIV = 2'd3
    } stall_class_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Hazard-information inputs and stage-control outputs of pipe_stall_ctrl.
// Stall counter outputs exist only when PIPE_CTRL_STATS_EN is defined.
interface pipe_stall_ctrl_if #(
    parameter int REG_W = 5
`ifdef PIPE_CTRL_STATS_EN
    , parameter int STAT_W = 32
`endif
);
    logic             IDEX_MemRead__i;
    logic             IDEX_RegWrite__i;
    logic             EXMEM_MemRead__i;
    logic             Branch__i;
    logic             BranchTaken__i;
    logic [REG_W-1:0] IFID_RegRs__i;
    logic [REG_W-1:0] IFID_RegRt__i;
    logic [REG_W-1:0] IDEX_RegRd__i;
    logic [REG_W-1:0] EXMEM_RegRd__i;
    logic             MulDivStart__i;
    logic             MulDivDone__i;
    logic             DMemReady__i;

    logic PC_En__o, IFID_En__o, IDEX_En__o, EXMEM_En__o, MEMWB_En__o;
    logic IFID_Flush__o, IDEX_Flush__o, EXMEM_Flush__o;
    logic Stall__o;
    logic MdTimeout__o;
`ifdef PIPE_CTRL_STATS_EN
    logic [STAT_W-1:0] LoadStalls__o, BrStalls__o, MdStalls__o;
`endif

    // Pipeline side: reports hazards, consumes the stage controls.
    modport master (
        output IDEX_MemRead__i, IDEX_RegWrite__i, EXMEM_MemRead__i, Branch__i, BranchTaken__i,
               IFID_RegRs__i, IFID_RegRt__i, IDEX_RegRd__i, EXMEM_RegRd__i,
               MulDivStart__i, MulDivDone__i, DMemReady__i,
        input  PC_En__o, IFID_En__o, IDEX_En__o, EXMEM_En__o, MEMWB_En__o,
               IFID_Flush__o, IDEX_Flush__o, EXMEM_Flush__o, Stall__o, MdTimeout__o
`ifdef PIPE_CTRL_STATS_EN
        , input LoadStalls__o, BrStalls__o, MdStalls__o
`endif
    );

    // Scheduler side.
    modport slave (
        input  IDEX_MemRead__i, IDEX_RegWrite__i, EXMEM_MemRead__i, Branch__i, BranchTaken__i,
               IFID_RegRs__i, IFID_RegRt__i, IDEX_RegRd__i, EXMEM_RegRd__i,
               MulDivStart__i, MulDivDone__i, DMemReady__i,
        output PC_En__o, IFID_En__o, IDEX_En__o, EXMEM_En__o, MEMWB_En__o,
               IFID_Flush__o, IDEX_Flush__o, EXMEM_Flush__o, Stall__o, MdTimeout__o
`ifdef PIPE_CTRL_STATS_EN
        , output LoadStalls__o, BrStalls__o, MdStalls__o
`endif
    );

endinterface

// File: rtl/pipe_stall_ctrl_hazard_cmp.sv
// Pure compare of the ID source registers (rs, rt) against one destination register.
// A zero source index never matches.
module hazard_cmp
    import mips_pipe_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    output logic             match
);

    assign match = ((rs != REG_W'(REG_ZERO)) && (rs == rd)) ||
                   ((rt != REG_W'(REG_ZERO)) && (rt == rd));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage MIPS pipeline: memory wait > mul/div > load-use/branch > taken flush.
// Optional stall counters are built when PIPE_CTRL_STATS_EN is defined.
module pipe_stall_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int MD_TIMEOUT = 64
`ifdef PIPE_CTRL_STATS_EN
    , parameter int STAT_W   = 32
`endif
) (
    input  logic             clock__i,
    input  logic             reset_n__i,
    pipe_stall_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

    state_t           state_reg, state_next, saved_reg, saved_next, eff_state, run_next;
    logic [CNT_W-1:0] md_cnt_reg, md_cnt_next;
    logic             md_timeout_reg, md_timeout_next;
    logic             mem_hold, md_stall, lu_stall, br_stall, br_load_go, load_hit;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_flush, exmem_flush;

    // Index 0 compares against the EX destination, index 1 against the MEM destination.
    logic [REG_W-1:0] dst_rd [2];
    logic [1:0]       match_vec;

    assign dst_rd[0] = bus.IDEX_RegRd__i;
    assign dst_rd[1] = bus.EXMEM_RegRd__i;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_cmp
        hazard_cmp #(.REG_W(REG_W)) u_cmp (
            .rs    (bus.IFID_RegRs__i),
            .rt    (bus.IFID_RegRt__i),
            .rd    (dst_rd[gi]),
            .match (match_vec[gi])
        );
    end

    always_comb begin
        // While memory waits, the interrupted state keeps deciding what happens after ready.
        eff_state  = (state_reg == MEM_WAIT) ? saved_reg : state_reg;
        mem_hold   = !bus.DMemReady__i && (bus.EXMEM_MemRead__i || (state_reg == MEM_WAIT));
        md_stall   = !bus.MulDivDone__i &&
                     ((eff_state == MD_WAIT) || ((eff_state == RUN) && bus.MulDivStart__i));
        load_hit   = bus.IDEX_MemRead__i && match_vec[0];
        lu_stall   = (eff_state == RUN) && !bus.Branch__i && load_hit;
        br_load_go = (eff_state == RUN) && bus.Branch__i && load_hit;
        br_stall   = (eff_state == BR_LOAD) || br_load_go ||
                     ((eff_state == RUN) && bus.Branch__i &&
                      ((bus.IDEX_RegWrite__i && match_vec[0]) ||
                       (bus.EXMEM_MemRead__i && match_vec[1])));
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        if (!reset_n__i) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end else if (mem_hold) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end else if (md_stall) begin
            {pc_en, ifid_en, idex_en} = '0;
            exmem_flush               = 1'b1;
        end else if (lu_stall || br_stall) begin
            {pc_en, ifid_en} = '0;
            idex_flush       = 1'b1;
        end else if (bus.BranchTaken__i) begin
            ifid_flush = 1'b1;
        end
    end

    assign bus.PC_En__o       = pc_en;
    assign bus.IFID_En__o     = ifid_en;
    assign bus.IDEX_En__o     = idex_en;
    assign bus.EXMEM_En__o    = exmem_en;
    assign bus.MEMWB_En__o    = memwb_en;
    assign bus.IFID_Flush__o  = ifid_flush;
    assign bus.IDEX_Flush__o  = idex_flush;
    assign bus.EXMEM_Flush__o = exmem_flush;
    assign bus.Stall__o       = reset_n__i && !pc_en;
    assign bus.MdTimeout__o   = md_timeout_reg;

    always_comb begin
        run_next        = eff_state;
        md_cnt_next     = md_cnt_reg;
        md_timeout_next = md_timeout_reg;
        case (eff_state)
            RUN: begin
                if (bus.MulDivStart__i && !bus.MulDivDone__i) begin
                    run_next    = MD_WAIT;
                    md_cnt_next = '0;
                end else if (br_load_go) begin
                    run_next = BR_LOAD;
                end
            end
            BR_LOAD: run_next = RUN;
            MD_WAIT: begin
                if (bus.MulDivDone__i)
                    run_next = RUN;
                else if (md_cnt_reg == CNT_W'(MD_TIMEOUT))
                    md_timeout_next = 1'b1;
                else
                    md_cnt_next = md_cnt_reg + 1'b1;
            end
            default: run_next = RUN;
        endcase

        // The mul/div unit keeps running during a memory wait; ID-stage stalls wait for ready.
        if (mem_hold) begin
            state_next = MEM_WAIT;
            saved_next = ((run_next == MD_WAIT) || (eff_state == MD_WAIT)) ? run_next : eff_state;
        end else begin
            state_next = run_next;
            saved_next = RUN;
        end
    end

    always_ff @(posedge clock__i or negedge reset_n__i) begin
        if (!reset_n__i) begin
            state_reg      <= RUN;
            saved_reg      <= RUN;
            md_cnt_reg     <= '0;
            md_timeout_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            saved_reg      <= saved_next;
            md_cnt_reg     <= md_cnt_next;
            md_timeout_reg <= md_timeout_next;
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    stall_class_t                stall_class;
    logic [2:0][STAT_W-1:0]      stat_vec;

    always_comb begin
        stall_class = SC_NONE;
        if (reset_n__i && !mem_hold) begin
            if (md_stall)      stall_class = SC_MULDIV;
            else if (lu_stall) stall_class = SC_LOAD;
            else if (br_stall) stall_class = SC_BRANCH;
        end
    end

    // Counter gi tracks stall class gi+1 and saturates at all-ones.
    for (gi = 0; gi < 3; gi++) begin : g_stat
        logic [STAT_W-1:0] cnt_reg;
        always_ff @(posedge clock__i or negedge reset_n__i) begin
            if (!reset_n__i)
                cnt_reg <= '0;
            else if ((stall_class == stall_class_t'(2'(gi + 1))) && (cnt_reg != '1))
                cnt_reg <= cnt_reg + 1'b1;
        end
        assign stat_vec[gi] = cnt_reg;
    end

    assign bus.LoadStalls__o = stat_vec[0];
    assign bus.BrStalls__o   = stat_vec[1];
    assign bus.MdStalls__o   = stat_vec[2];
`endif

endmodule
